dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, dmem word-address width.
REQ-002 Parameter DATA_W, default 32, dmem data width.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset.
REQ-004 clock  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 cpu_req, cpu_wren  in  1 each  processor access request; write when cpu_wren=1.
REQ-007 cpu_addr  in  ADDR_W  processor address; cpu_wdata  in  DATA_W  processor write data.
REQ-008 cpu_gnt  out  1  one-cycle grant pulse; cpu_rvalid  out  1  read data valid; cpu_rdata  out  DATA_W.
REQ-009 ldr_req, ldr_wren, ldr_addr, ldr_wdata, ldr_gnt, ldr_rvalid, ldr_rdata: same widths and meanings for the loader/debug requester.
REQ-010 mem_address  out  ADDR_W, mem_data  out  DATA_W, mem_wren  out  1: to dmem syncram.
REQ-011 mem_q  in  DATA_W  dmem registered read data.

Function
REQ-012 FSM states: IDLE, ISSUE, RESP; one access in flight maximum.
REQ-013 IDLE: if any req=1, pulse the winner's gnt for that cycle (N), register its addr/wdata/wren into mem_* and the winner id, and go to ISSUE; otherwise stay in IDLE.
REQ-014 Requester SHALL hold req, wren, addr and wdata stable until its gnt; gnt deasserts the next cycle regardless of req.
REQ-015 ISSUE (cycle N+1): mem_wren SHALL equal the latched wren; mem_address/mem_data hold latched values; next state RESP.
REQ-016 RESP (cycle N+2): for a read, winner's rvalid=1 for exactly this cycle and its rdata=mem_q; for a write, no rvalid; next state IDLE.
REQ-017 mem_wren SHALL be 0 in every state other than ISSUE; mem_address/mem_data hold their last value outside ISSUE.
REQ-018 cpu_rdata and ldr_rdata SHALL both be driven from mem_q; only rvalid discriminates.
REQ-019 Throughput: at most one grant per 3 cycles; back-to-back grants at N and N+3.
REQ-020 Simultaneous requests in IDLE: resolved per Configuration; exactly one gnt is ever asserted.
REQ-021 A req raised during ISSUE or RESP SHALL be considered only on the next IDLE cycle.

Reset
REQ-022 With reset=0 at a rising edge: state=IDLE; cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, mem_wren=0; mem_address, mem_data=0; last-grant pointer=loader.
REQ-023 Reset during ISSUE or RESP SHALL abort the access: no rvalid is produced and mem_wren is 0 from the cycle after reset is sampled.

Configuration
REQ-024 Macro DMEM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant the requester not granted most recently; pointer updates on every grant.
REQ-025 Macro undefined: cpu always wins ties (fixed priority); the last-grant pointer is not implemented; the loader may starve.

Structure
REQ-026 Shared package dmem_arb_pkg SHALL hold the FSM state enum (IDLE, ISSUE, RESP), the requester-id enum (CPU, LDR), and ADDR_W/DATA_W defaults.
REQ-027 One sub-module, dmem_arb_pick: combinational two-way winner selection from req bits and the last-grant pointer; the FSM stays in dmem_arbiter.

Verification
REQ-028 Reset low 2 cycles then high, no reqs -> all gnt/rvalid/mem_wren 0, mem_address=0 for 10 cycles.
REQ-029 cpu_req write addr=0x010 data=0xDEADBEEF at N -> cpu_gnt at N, mem_wren=1 only at N+1 with mem_address=0x010, no cpu_rvalid.
REQ-030 Following cpu read addr=0x010 -> cpu_rvalid exactly one cycle, 2 cycles after cpu_gnt, cpu_rdata=0xDEADBEEF; ldr_rvalid stays 0.
REQ-031 cpu_req and ldr_req both held continuously (reads) with DMEM_ARB_ROUND_ROBIN_EN -> grants alternate CPU, LDR, CPU, LDR, spaced 3 cycles; without macro -> only CPU granted.
REQ-032 ldr write addr=0xFFF data=0x1 with reset asserted during ISSUE -> mem_wren 0 after reset, no rvalid, state IDLE, subsequent read of 0xFFF proceeds normally.
REQ-033 ldr_req raised during cpu ISSUE -> ldr_gnt no earlier than the next IDLE cycle (N+3).

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the two-requester data-memory arbiter.
// Round-robin tie-break is selected with DMEM_ARB_ROUND_ROBIN_EN.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_e;

  typedef enum logic {
    CPU,
    LDR
  } req_id_e;

endpackage

// File: rtl/dmem_arb_pick.sv
// Two-way winner selection between the cpu and loader requesters.
// On a tie the requester not granted most recently wins.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic    cpu_req_i,
  input  logic    ldr_req_i,
  input  req_id_e last_i,
  output logic    valid_o,
  output req_id_e id_o
);

  always_comb begin
    valid_o = cpu_req_i | ldr_req_i;
    id_o    = CPU;
    unique case (1'b1)
      (cpu_req_i & ldr_req_i):
        id_o = (last_i == CPU) ? LDR : CPU;
      (ldr_req_i & ~cpu_req_i):
        id_o = LDR;
      default:
        id_o = CPU;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: cpu vs loader, one access in flight.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin ties.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              cpu_req,
  input  logic              cpu_wren,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,

  input  logic              ldr_req,
  input  logic              ldr_wren,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,

  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  state_e            state_q;
  req_id_e           id_q;
  logic              wren_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              mem_wren_q;
  logic              cpu_rv_q;
  logic              ldr_rv_q;

  logic              win_v;
  req_id_e           win_id;
  logic              take;
  logic              sel_wren;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  req_id_e last_q;
`else
  localparam req_id_e last_q = LDR;
`endif

  dmem_arb_pick u_pick (
    .cpu_req_i (cpu_req),
    .ldr_req_i (ldr_req),
    .last_i    (last_q),
    .valid_o   (win_v),
    .id_o      (win_id)
  );

  // Grant is a same-cycle pulse, suppressed while reset is held.
  assign take    = reset & (state_q == IDLE) & win_v;
  assign cpu_gnt = take & (win_id == CPU);
  assign ldr_gnt = take & (win_id == LDR);

  assign sel_wren = (win_id == LDR) ? ldr_wren  : cpu_wren;
  assign sel_addr = (win_id == LDR) ? ldr_addr  : cpu_addr;
  assign sel_data = (win_id == LDR) ? ldr_wdata : cpu_wdata;

  assign mem_address = addr_q;
  assign mem_data    = data_q;
  assign mem_wren    = mem_wren_q;
  assign cpu_rvalid  = cpu_rv_q;
  assign ldr_rvalid  = ldr_rv_q;
  assign cpu_rdata   = mem_q;
  assign ldr_rdata   = mem_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      id_q       <= CPU;
      wren_q     <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      mem_wren_q <= 1'b0;
      cpu_rv_q   <= 1'b0;
      ldr_rv_q   <= 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      last_q     <= LDR;
`endif
    end else begin
      mem_wren_q <= 1'b0;
      cpu_rv_q   <= 1'b0;
      ldr_rv_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (take) begin
            state_q    <= ISSUE;
            id_q       <= win_id;
            wren_q     <= sel_wren;
            addr_q     <= sel_addr;
            data_q     <= sel_data;
            mem_wren_q <= sel_wren;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_q     <= win_id;
`endif
          end
        end
        ISSUE: begin
          state_q  <= RESP;
          cpu_rv_q <= ~wren_q & (id_q == CPU);
          ldr_rv_q <= ~wren_q & (id_q == LDR);
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table,
// response scoreboard and multi-cycle corner sequences.
module tb_dmem_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_wren;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          ldr_req, ldr_wren;
  logic [AW-1:0] ldr_addr;
  logic [DW-1:0] ldr_wdata;
  logic          ldr_gnt, ldr_rvalid;
  logic [DW-1:0] ldr_rdata;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data;
  logic          mem_wren;
  logic [DW-1:0] mem_q = '0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    bit            ldr;
    bit            wren;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } vec_t;

  typedef struct {
    bit            ldr;
    logic [DW-1:0] data;
    int            cyc;
  } rsp_t;

  rsp_t sbq[$];
  vec_t tbl[10];

  logic [DW-1:0] ram [1<<AW] = '{default: '0};

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock       (clock),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_wren    (cpu_wren),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_gnt     (cpu_gnt),
    .cpu_rvalid  (cpu_rvalid),
    .cpu_rdata   (cpu_rdata),
    .ldr_req     (ldr_req),
    .ldr_wren    (ldr_wren),
    .ldr_addr    (ldr_addr),
    .ldr_wdata   (ldr_wdata),
    .ldr_gnt     (ldr_gnt),
    .ldr_rvalid  (ldr_rvalid),
    .ldr_rdata   (ldr_rdata),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Syncram with registered read data (old data on collision).
  always @(posedge clock) begin
    if (mem_wren) ram[mem_address] <= mem_data;
    mem_q <= ram[mem_address];
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (cpu_rvalid || ldr_rvalid) begin
      if (sbq.size() == 0) begin
        chk("rvalid_unexpected", 32'({cpu_rvalid, ldr_rvalid}), 0);
      end else begin
        rsp_t e;
        e = sbq.pop_front();
        chk("rsp_who", 32'({cpu_rvalid, ldr_rvalid}),
            e.ldr ? 32'd1 : 32'd2);
        chk("rsp_cyc", cyc, e.cyc + 2);
        chk("rsp_data", e.ldr ? ldr_rdata : cpu_rdata, e.data);
      end
    end
  end

  task automatic drive(input bit ldr, input bit req, input bit wren,
                       input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata);
    if (ldr) begin
      ldr_req = req; ldr_wren = wren;
      ldr_addr = addr; ldr_wdata = wdata;
    end else begin
      cpu_req = req; cpu_wren = wren;
      cpu_addr = addr; cpu_wdata = wdata;
    end
  endtask

  task automatic idle_reqs();
    cpu_req = 1'b0;
    ldr_req = 1'b0;
  endtask

  task automatic access(input vec_t v);
    bit got;
    int lat;
    @(posedge clock); #1;
    drive(v.ldr, 1'b1, v.wren, v.addr, v.wdata);
    got = 0;
    lat = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clock);
      if (v.ldr ? ldr_gnt : cpu_gnt) begin
        got = 1;
        lat = n;
      end
    end
    chk("gnt_seen", 32'(got), 1);
    if (!got) begin
      idle_reqs();
      return;
    end
    chk("gnt_lat", lat, 0);
    chk("gnt_other", 32'(v.ldr ? cpu_gnt : ldr_gnt), 0);
    chk("wren_at_n", 32'(mem_wren), 0);
    if (!v.wren) sbq.push_back('{ldr: v.ldr, data: v.rdata, cyc: cyc});
    @(posedge clock); #1;
    idle_reqs();
    @(negedge clock);
    chk("gnt_drop", 32'(cpu_gnt | ldr_gnt), 0);
    chk("wren_n1", 32'(mem_wren), 32'(v.wren));
    chk("addr_n1", 32'(mem_address), 32'(v.addr));
    if (v.wren) chk("data_n1", mem_data, v.wdata);
    @(negedge clock);
    chk("wren_n2", 32'(mem_wren), 0);
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  initial begin
    int ng;
    int lastc;
    int gc;
    bit got;
    bit exp_ldr;

    tbl[0] = '{0, 1, 12'h010, 32'hDEADBEEF, 32'h0};
    tbl[1] = '{0, 0, 12'h010, 32'h0, 32'hDEADBEEF};
    tbl[2] = '{1, 1, 12'h020, 32'h12345678, 32'h0};
    tbl[3] = '{0, 0, 12'h020, 32'h0, 32'h12345678};
    tbl[4] = '{1, 0, 12'h010, 32'h0, 32'hDEADBEEF};
    tbl[5] = '{0, 1, 12'hFFF, 32'hA5A5A5A5, 32'h0};
    tbl[6] = '{1, 0, 12'hFFF, 32'h0, 32'hA5A5A5A5};
    tbl[7] = '{0, 0, 12'h000, 32'h0, 32'h0};
    tbl[8] = '{1, 1, 12'h000, 32'hFFFFFFFF, 32'h0};
    tbl[9] = '{0, 0, 12'h000, 32'h0, 32'hFFFFFFFF};

    reset = 1'b0;
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("rst_outs", 32'({cpu_gnt, ldr_gnt, cpu_rvalid,
                           ldr_rvalid, mem_wren}), 0);
      chk("rst_addr", 32'(mem_address), 0);
    end

    foreach (tbl[i]) access(tbl[i]);

    // Loader request arriving while a cpu read is in ISSUE.
    @(posedge clock); #1;
    drive(0, 1, 0, 12'h010, '0);
    got = 0;
    gc = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clock);
      if (cpu_gnt) begin got = 1; gc = cyc; end
    end
    chk("late_cpu_gnt", 32'(got), 1);
    sbq.push_back('{ldr: 0, data: 32'hDEADBEEF, cyc: gc});
    @(posedge clock); #1;
    cpu_req = 1'b0;
    drive(1, 1, 0, 12'h020, '0);
    got = 0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clock);
      if (ldr_gnt) got = 1;
    end
    chk("late_ldr_gnt", 32'(got), 1);
    chk("late_ldr_gnt_cyc", cyc - gc, 3);
    if (got) sbq.push_back('{ldr: 1, data: 32'h12345678, cyc: cyc});
    @(posedge clock); #1;
    idle_reqs();
    repeat (4) @(negedge clock);

    // Both requesters held continuously.
    do_reset();
    @(posedge clock); #1;
    drive(0, 1, 0, 12'h010, '0);
    drive(1, 1, 0, 12'h020, '0);
    ng = 0;
    lastc = 0;
    for (int n = 0; n < 40 && ng < 4; n++) begin
      @(negedge clock);
      if (cpu_gnt || ldr_gnt) begin
        chk("onehot_gnt", 32'(cpu_gnt & ldr_gnt), 0);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        exp_ldr = ng[0];
`else
        exp_ldr = 1'b0;
`endif
        chk("tie_winner", 32'(ldr_gnt), 32'(exp_ldr));
        if (ng > 0) chk("gnt_spacing", cyc - lastc, 3);
        sbq.push_back('{ldr: ldr_gnt,
                        data: ldr_gnt ? 32'h12345678 : 32'hDEADBEEF,
                        cyc: cyc});
        lastc = cyc;
        ng++;
      end
    end
    chk("tie_grants", ng, 4);
    @(posedge clock); #1;
    idle_reqs();
    repeat (4) @(negedge clock);

    // Loader write aborted by reset while in ISSUE.
    @(posedge clock); #1;
    drive(1, 1, 1, 12'hFFF, 32'h1);
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clock);
      if (ldr_gnt) got = 1;
    end
    chk("abort_gnt", 32'(got), 1);
    @(posedge clock); #1;
    idle_reqs();
    reset = 1'b0;
    @(negedge clock);
    chk("abort_issue_wren", 32'(mem_wren), 1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("abort_wren", 32'(mem_wren), 0);
    chk("abort_addr", 32'(mem_address), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("abort_quiet", 32'({mem_wren, cpu_rvalid, ldr_rvalid}), 0);
    end
    access('{1, 0, 12'hFFF, 32'h0, 32'h1});

    repeat (5) @(negedge clock);
    chk("sb_empty", 32'(sbq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
